// File: rtl/spi_cfg_regfile.sv
// Management SPI slave (oversampled in clk) fronting a shadowed, lockable config register file.
// Latency: pins see 2 clk sync + 1 clk edge detect; commit lands 1 clk after synced CS rise, with cfg_update.
// Backpressure: none; SCK high/low must each last >= 3 clk or bits are missed.
module spi_cfg_regfile #(
    parameter int         NUM_RANGES = 2,
    parameter int         AW         = 24,
    parameter logic [7:0] ID_VALUE   = 8'hA2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mgmt_clk,
    input  logic                       mgmt_cs_n,
    input  logic                       mgmt_mosi,
    output logic                       mgmt_miso,
    output logic [NUM_RANGES*AW-1:0]   range_start,
    output logic [NUM_RANGES*AW-1:0]   range_end,
    output logic [NUM_RANGES-1:0]      range_enable,
    output logic [NUM_RANGES-1:0]      range_flash_select,
    output logic [7:0]                 control_reg,
    output logic [7:0]                 status_reg,
    output logic                       cfg_update
);
    localparam int         NB     = AW / 8;
    localparam int         NWIN   = 2 * NB * NUM_RANGES;
    localparam int         WIW    = (NWIN > 1) ? $clog2(NWIN) : 1;
    localparam logic [7:0] NWIN_B = 8'(NWIN);

    localparam logic [7:0] A_CONTROL   = 8'hF0;
    localparam logic [7:0] A_STATUS    = 8'hF1;
    localparam logic [7:0] A_ID        = 8'hF2;
    localparam logic [7:0] A_RANGE_EN  = 8'hF3;
    localparam logic [7:0] A_FLASH_SEL = 8'hF4;

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        CMD,
        ADDR,
        DATA
    } state_t;

    state_t state_q, state_d;

    logic [1:0] sck_s, cs_s, mosi_s;
    logic       sck_d, cs_d;
    logic [1:0] sync_vld;
    logic       sck_rise, sck_fall, cs_rise, cs_sync, sync_ok;

    logic [2:0] bit_cnt;
    logic [6:0] rx_sh;
    logic [7:0] rx_byte;
    logic [7:0] ptr;
    logic [7:0] tx_sh;
    logic       in_frame, byte_done;
    logic       rd_frame, wr_frame, dirty;
    logic       wr_reject, bad_cmd;

    logic [7:0]            win_sh [NWIN];
    logic [7:0]            win_q  [NWIN];
    logic [7:0]            ctrl_sh, ctrl_q;
    logic [NUM_RANGES-1:0] en_sh, en_q, fs_sh, fs_q;

    logic [7:0]     rd_addr, rd_data;
    logic [WIW-1:0] rd_idx, wr_idx;
    logic           lock;

    assign cs_sync  = cs_s[1];
    assign sync_ok  = sync_vld[1];
    assign sck_rise = sck_s[1] & ~sck_d;
    assign sck_fall = ~sck_s[1] & sck_d;
    assign cs_rise  = cs_s[1] & ~cs_d;

    assign in_frame  = (state_q == CMD) || (state_q == ADDR) || (state_q == DATA);
    assign byte_done = in_frame && sck_rise && (bit_cnt == 3'd7);
    assign rx_byte   = {rx_sh, mosi_s[1]};
    assign lock      = ctrl_sh[7];

    // The byte to preload: the address itself while it completes, else the next pointer.
    assign rd_addr = (state_q == ADDR) ? rx_byte : ptr + 8'd1;
    assign rd_idx  = rd_addr[WIW-1:0];
    assign wr_idx  = ptr[WIW-1:0];

    always_comb begin
        rd_data = 8'hFF;
        if (rd_addr < NWIN_B) begin
            rd_data = win_sh[rd_idx];
        end else begin
            case (rd_addr)
                A_CONTROL:   rd_data = ctrl_sh;
                // Frame-activity bits are fixed from the reading host's view; only sticky flags return.
                A_STATUS:    rd_data = {3'b000, bad_cmd, wr_reject, 3'b000};
                A_ID:        rd_data = ID_VALUE;
                A_RANGE_EN:  rd_data = 8'(en_sh);
                A_FLASH_SEL: rd_data = 8'(fs_sh);
                default:     rd_data = 8'hFF;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_IDLE: if (sync_ok && cs_sync) state_d = IDLE;
            IDLE:      if (sync_ok && !cs_sync) state_d = CMD;
            CMD: begin
                if (byte_done) begin
                    if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) state_d = ADDR;
                    else                                              state_d = WAIT_IDLE;
                end
            end
            ADDR:      if (byte_done) state_d = DATA;
            DATA:      state_d = DATA;
            default:   state_d = WAIT_IDLE;
        endcase
        if (cs_rise && state_q != WAIT_IDLE) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= WAIT_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // CS sync resets high so a frame already in flight never looks like a fresh select.
            sck_s      <= 2'b00;
            cs_s       <= 2'b11;
            mosi_s     <= 2'b00;
            sck_d      <= 1'b0;
            cs_d       <= 1'b1;
            sync_vld   <= 2'b00;
            bit_cnt    <= 3'd0;
            rx_sh      <= 7'd0;
            ptr        <= 8'd0;
            tx_sh      <= 8'd0;
            mgmt_miso  <= 1'b0;
            rd_frame   <= 1'b0;
            wr_frame   <= 1'b0;
            dirty      <= 1'b0;
            wr_reject  <= 1'b0;
            bad_cmd    <= 1'b0;
            cfg_update <= 1'b0;
            ctrl_sh    <= 8'd0;
            ctrl_q     <= 8'd0;
            en_sh      <= '0;
            en_q       <= '0;
            fs_sh      <= '0;
            fs_q       <= '0;
            for (int i = 0; i < NWIN; i++) begin
                win_sh[i] <= 8'hFF;
                win_q[i]  <= 8'hFF;
            end
        end else begin
            sck_s    <= {sck_s[0], mgmt_clk};
            cs_s     <= {cs_s[0], mgmt_cs_n};
            mosi_s   <= {mosi_s[0], mgmt_mosi};
            sck_d    <= sck_s[1];
            cs_d     <= cs_s[1];
            sync_vld <= {sync_vld[0], 1'b1};

            if (!in_frame) begin
                bit_cnt <= 3'd0;
            end else if (sck_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                rx_sh   <= rx_byte[6:0];
            end

            if (byte_done && state_q == CMD) begin
                if (rx_byte == CMD_READ)       rd_frame <= 1'b1;
                else if (rx_byte == CMD_WRITE) wr_frame <= 1'b1;
                else                           bad_cmd  <= 1'b1;
            end

            if (byte_done && state_q == ADDR) begin
                ptr <= rx_byte;
                if (rd_frame) tx_sh <= rd_data;
            end

            if (byte_done && state_q == DATA) begin
                ptr <= ptr + 8'd1;
                if (rd_frame) begin
                    tx_sh <= rd_data;
                    if (ptr == A_STATUS) begin
                        wr_reject <= 1'b0;
                        bad_cmd   <= 1'b0;
                    end
                end
                if (wr_frame) begin
                    if (ptr < NWIN_B) begin
                        if (lock) wr_reject <= 1'b1;
                        else begin
                            win_sh[wr_idx] <= rx_byte;
                            dirty          <= 1'b1;
                        end
                    end else begin
                        case (ptr)
                            A_CONTROL: begin
                                // The lock bit is sticky until reset.
                                ctrl_sh <= rx_byte | (ctrl_sh & 8'h80);
                                dirty   <= 1'b1;
                            end
                            A_RANGE_EN: begin
                                if (lock) wr_reject <= 1'b1;
                                else begin
                                    en_sh <= rx_byte[NUM_RANGES-1:0];
                                    dirty <= 1'b1;
                                end
                            end
                            A_FLASH_SEL: begin
                                if (lock) wr_reject <= 1'b1;
                                else begin
                                    fs_sh <= rx_byte[NUM_RANGES-1:0];
                                    dirty <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end

            if (cs_sync || !(state_q == DATA && rd_frame)) begin
                mgmt_miso <= 1'b0;
            end else if (sck_fall) begin
                mgmt_miso <= tx_sh[7];
                tx_sh     <= {tx_sh[6:0], 1'b0};
            end

            cfg_update <= cs_rise && dirty;
            if (cs_rise) begin
                rd_frame <= 1'b0;
                wr_frame <= 1'b0;
                dirty    <= 1'b0;
                if (dirty) begin
                    win_q  <= win_sh;
                    ctrl_q <= ctrl_sh;
                    en_q   <= en_sh;
                    fs_q   <= fs_sh;
                end
            end
        end
    end

    for (genvar r = 0; r < NUM_RANGES; r++) begin : g_rng
        for (genvar b = 0; b < NB; b++) begin : g_byte
            assign range_start[r*AW + (NB-1-b)*8 +: 8] = win_q[r*2*NB + b];
            assign range_end[r*AW + (NB-1-b)*8 +: 8]   = win_q[r*2*NB + NB + b];
        end
    end

    assign range_enable       = en_q;
    assign range_flash_select = fs_q;
    assign control_reg        = ctrl_q;
    assign status_reg         = {3'b000, bad_cmd, wr_reject, wr_frame, rd_frame, ~cs_sync};

endmodule

// File: tb/tb_spi_cfg_regfile.sv
// Bench for spi_cfg_regfile: fixed frame table, hand sequences for reset/lock/CS corner cases, random frames vs model.
module tb_spi_cfg_regfile;
    localparam int HALF = 4;
    localparam int NR   = 2;
    localparam int AWB  = 24;
    localparam int NWIN = 12;
    localparam logic [47:0] ALL1 = 48'hFFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst, mgmt_clk, mgmt_cs_n, mgmt_mosi;
    logic mgmt_miso, cfg_update;
    logic [NR*AWB-1:0] range_start, range_end;
    logic [NR-1:0]     range_enable, range_flash_select;
    logic [7:0]        control_reg, status_reg;

    spi_cfg_regfile #(.NUM_RANGES(NR), .AW(AWB), .ID_VALUE(8'hA2)) dut (
        .clk(clk), .rst(rst), .mgmt_clk(mgmt_clk), .mgmt_cs_n(mgmt_cs_n),
        .mgmt_mosi(mgmt_mosi), .mgmt_miso(mgmt_miso), .range_start(range_start),
        .range_end(range_end), .range_enable(range_enable),
        .range_flash_select(range_flash_select), .control_reg(control_reg),
        .status_reg(status_reg), .cfg_update(cfg_update)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int upd_cnt = 0;
    always @(negedge clk) if (cfg_update === 1'b1) upd_cnt++;

    logic [7:0] tx_b [16];
    logic [7:0] rx_b [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer(input int len);
        for (int k = 0; k < len; k++) begin
            for (int i = 7; i >= 0; i--) begin
                mgmt_mosi = tx_b[k][i];
                idle(HALF);
                rx_b[k][i] = mgmt_miso;
                mgmt_clk = 1'b1;
                idle(HALF);
                mgmt_clk = 1'b0;
            end
        end
    endtask

    task automatic frame(input int len);
        mgmt_cs_n = 1'b0;
        idle(HALF);
        xfer(len);
        idle(HALF);
        mgmt_cs_n = 1'b1;
        idle(3 * HALF);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(4);
    endtask

    task automatic load_tx(input logic [63:0] t, input int len);
        for (int k = 0; k < len; k++) tx_b[k] = t[63 - 8*k -: 8];
    endtask

    // Behavioural model: byte-addressed register map with shadow and committed copies.
    logic [7:0] m_win [NWIN];
    logic [7:0] c_win [NWIN];
    logic [7:0] m_ctrl, c_ctrl;
    logic [1:0] m_en, c_en, m_fs, c_fs;
    logic       m_rej, m_bad, m_dirty;

    task automatic m_reset();
        for (int i = 0; i < NWIN; i++) begin
            m_win[i] = 8'hFF;
            c_win[i] = 8'hFF;
        end
        m_ctrl = 0; c_ctrl = 0; m_en = 0; c_en = 0; m_fs = 0; c_fs = 0;
        m_rej = 0; m_bad = 0; m_dirty = 0;
    endtask

    function automatic logic [7:0] m_read(input logic [7:0] a);
        if (int'(a) < NWIN) return m_win[a];
        case (a)
            8'hF0:   return m_ctrl;
            8'hF1:   return {3'b000, m_bad, m_rej, 3'b000};
            8'hF2:   return 8'hA2;
            8'hF3:   return {6'd0, m_en};
            8'hF4:   return {6'd0, m_fs};
            default: return 8'hFF;
        endcase
    endfunction

    task automatic m_write(input logic [7:0] a, input logic [7:0] d);
        if (int'(a) < NWIN || a == 8'hF3 || a == 8'hF4) begin
            if (m_ctrl[7]) m_rej = 1'b1;
            else begin
                m_dirty = 1'b1;
                if (a == 8'hF3)      m_en = d[1:0];
                else if (a == 8'hF4) m_fs = d[1:0];
                else                 m_win[a] = d;
            end
        end else if (a == 8'hF0) begin
            m_ctrl  = {m_ctrl[7] | d[7], d[6:0]};
            m_dirty = 1'b1;
        end
    endtask

    function automatic logic [47:0] m_rs();
        logic [47:0] v;
        for (int r = 0; r < NR; r++)
            for (int b = 0; b < 3; b++) v[r*24 + (2-b)*8 +: 8] = c_win[r*6 + b];
        return v;
    endfunction

    function automatic logic [47:0] m_re();
        logic [47:0] v;
        for (int r = 0; r < NR; r++)
            for (int b = 0; b < 3; b++) v[r*24 + (2-b)*8 +: 8] = c_win[r*6 + 3 + b];
        return v;
    endfunction

    typedef struct packed {
        logic [3:0]  len;
        logic [63:0] tx;
        logic [63:0] rx;
        logic [7:0]  rxm;
        logic [47:0] rs;
        logic [47:0] re;
        logic [1:0]  en;
        logic [1:0]  fs;
        logic [7:0]  ctrl;
        logic [7:0]  stat;
        logic [1:0]  upd;
    } vec_t;

    localparam int NV = 13;
    vec_t tbl [NV];

    initial begin
        int u0;
        logic [47:0] rs0, rs1, re0;
        logic [7:0]  exp_rx [16];
        logic [7:0]  cmd, addr, a, d;
        int          nd, kind;

        rs0 = 48'hFFFFFF_123456;
        rs1 = 48'hFFFF77_123456;
        re0 = 48'hFFFFFF_ABCDEF;
        tbl[0]  = '{4'd8, 64'h0200123456ABCDEF, 64'h0, 8'hFF, rs0, re0, 2'd0, 2'd0, 8'h00, 8'h00, 2'd1};
        tbl[1]  = '{4'd8, 64'h0300000000000000, 64'h0000123456ABCDEF, 8'hFF, rs0, re0, 2'd0, 2'd0, 8'h00, 8'h00, 2'd0};
        tbl[2]  = '{4'd4, 64'h03FF000000000000, 64'h0000FF1200000000, 8'hF0, rs0, re0, 2'd0, 2'd0, 8'h00, 8'h00, 2'd0};
        tbl[3]  = '{4'd3, 64'h03F2000000000000, 64'h0000A20000000000, 8'hE0, rs0, re0, 2'd0, 2'd0, 8'h00, 8'h00, 2'd0};
        tbl[4]  = '{4'd3, 64'h03F9000000000000, 64'h0000FF0000000000, 8'hE0, rs0, re0, 2'd0, 2'd0, 8'h00, 8'h00, 2'd0};
        tbl[5]  = '{4'd3, 64'h5500000000000000, 64'h0, 8'hE0, rs0, re0, 2'd0, 2'd0, 8'h00, 8'h10, 2'd0};
        tbl[6]  = '{4'd4, 64'h03F1000000000000, 64'h000010A200000000, 8'hF0, rs0, re0, 2'd0, 2'd0, 8'h00, 8'h00, 2'd0};
        tbl[7]  = '{4'd3, 64'h02F3030000000000, 64'h0, 8'hE0, rs0, re0, 2'd3, 2'd0, 8'h00, 8'h00, 2'd1};
        tbl[8]  = '{4'd3, 64'h0208770000000000, 64'h0, 8'hE0, rs1, re0, 2'd3, 2'd0, 8'h00, 8'h00, 2'd1};
        tbl[9]  = '{4'd4, 64'h02F1555500000000, 64'h0, 8'hF0, rs1, re0, 2'd3, 2'd0, 8'h00, 8'h00, 2'd0};
        tbl[10] = '{4'd3, 64'h02F0410000000000, 64'h0, 8'hE0, rs1, re0, 2'd3, 2'd0, 8'h41, 8'h00, 2'd1};
        tbl[11] = '{4'd3, 64'h02F4020000000000, 64'h0, 8'hE0, rs1, re0, 2'd3, 2'd2, 8'h41, 8'h00, 2'd1};
        tbl[12] = '{4'd4, 64'h03F3000000000000, 64'h0000030200000000, 8'hF0, rs1, re0, 2'd3, 2'd2, 8'h41, 8'h00, 2'd0};

        rst = 1'b1; mgmt_clk = 1'b0; mgmt_cs_n = 1'b1; mgmt_mosi = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(4);

        chk("rst_range_start", range_start, ALL1);
        chk("rst_range_end", range_end, ALL1);
        chk("rst_enable", range_enable, 0);
        chk("rst_flash_sel", range_flash_select, 0);
        chk("rst_control", control_reg, 0);
        chk("rst_status", status_reg, 0);
        chk("rst_miso", mgmt_miso, 0);
        chk("rst_cfg_update", cfg_update, 0);

        for (int v = 0; v < NV; v++) begin
            load_tx(tbl[v].tx, int'(tbl[v].len));
            u0 = upd_cnt;
            frame(int'(tbl[v].len));
            for (int k = 0; k < int'(tbl[v].len); k++)
                if (tbl[v].rxm[7-k]) chk($sformatf("v%0d_miso_b%0d", v, k), rx_b[k], tbl[v].rx[63 - 8*k -: 8]);
            chk($sformatf("v%0d_range_start", v), range_start, tbl[v].rs);
            chk($sformatf("v%0d_range_end", v), range_end, tbl[v].re);
            chk($sformatf("v%0d_enable", v), range_enable, tbl[v].en);
            chk($sformatf("v%0d_flash_sel", v), range_flash_select, tbl[v].fs);
            chk($sformatf("v%0d_control", v), control_reg, tbl[v].ctrl);
            chk($sformatf("v%0d_status", v), status_reg, tbl[v].stat);
            chk($sformatf("v%0d_cfg_update", v), upd_cnt - u0, tbl[v].upd);
            chk($sformatf("v%0d_miso_idle", v), mgmt_miso, 0);
        end

        // Reset while CS is still low: the frame must be thrown away.
        do_reset();
        load_tx(64'h0200123456ABCDEF, 8);
        u0 = upd_cnt;
        mgmt_cs_n = 1'b0;
        idle(HALF);
        xfer(8);
        idle(HALF);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(HALF);
        mgmt_cs_n = 1'b1;
        idle(3 * HALF);
        chk("rstmid_range_start", range_start, ALL1);
        chk("rstmid_range_end", range_end, ALL1);
        chk("rstmid_cfg_update", upd_cnt - u0, 0);
        u0 = upd_cnt;
        frame(8);
        chk("rstmid_next_start", range_start, rs0);
        chk("rstmid_next_end", range_end, re0);
        chk("rstmid_next_update", upd_cnt - u0, 1);

        // CS toggle with no SCK.
        u0 = upd_cnt;
        mgmt_cs_n = 1'b0;
        idle(HALF);
        chk("cs_only_status_low", status_reg, 8'h01);
        mgmt_cs_n = 1'b1;
        idle(3 * HALF);
        chk("cs_only_update", upd_cnt - u0, 0);
        chk("cs_only_status_high", status_reg, 8'h00);

        // Lock sequence.
        load_tx(64'h02F0800000000000, 3); u0 = upd_cnt; frame(3);
        chk("lock_control", control_reg, 8'h80);
        chk("lock_update", upd_cnt - u0, 1);
        load_tx(64'h0200000000000000, 3); u0 = upd_cnt; frame(3);
        chk("locked_start", range_start, rs0);
        chk("locked_update", upd_cnt - u0, 0);
        chk("locked_status", status_reg, 8'h08);
        load_tx(64'h02F3010000000000, 3); frame(3);
        chk("locked_enable", range_enable, 0);
        load_tx(64'h03F1000000000000, 3); frame(3);
        chk("locked_stat_rd1", rx_b[2], 8'h08);
        chk("locked_stat_clr", status_reg, 8'h00);
        load_tx(64'h03F1000000000000, 3); frame(3);
        chk("locked_stat_rd2", rx_b[2], 8'h00);
        load_tx(64'h02F0000000000000, 3); u0 = upd_cnt; frame(3);
        chk("lock_sticky", control_reg, 8'h80);
        chk("lock_sticky_update", upd_cnt - u0, 1);

        // Random frames against the model.
        do_reset();
        m_reset();
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            if (kind < 6)      cmd = 8'h02;
            else if (kind < 9) cmd = 8'h03;
            else               cmd = 8'($urandom_range(4, 255));
            case ($urandom_range(0, 5))
                0, 1, 2: addr = 8'($urandom_range(0, NWIN - 1));
                3:       addr = 8'hF0 + 8'($urandom_range(0, 4));
                4:       addr = 8'hFE;
                default: addr = 8'($urandom_range(0, 255));
            endcase
            nd = $urandom_range(1, 4);
            tx_b[0] = cmd; tx_b[1] = addr;
            exp_rx[0] = 0; exp_rx[1] = 0;
            if (cmd != 8'h02 && cmd != 8'h03) m_bad = 1'b1;
            for (int j = 0; j < nd; j++) begin
                a = addr + 8'(j);
                d = 8'($urandom_range(0, 255));
                if (a == 8'hF0) d[7] = 1'b0;
                tx_b[2+j] = d;
                exp_rx[2+j] = 0;
                if (cmd == 8'h03) begin
                    exp_rx[2+j] = m_read(a);
                    if (a == 8'hF1) begin m_rej = 0; m_bad = 0; end
                end else if (cmd == 8'h02) begin
                    m_write(a, d);
                end
            end
            u0 = upd_cnt;
            frame(2 + nd);
            for (int k = 0; k < 2 + nd; k++) chk($sformatf("r%0d_miso_b%0d", n, k), rx_b[k], exp_rx[k]);
            if (m_dirty) begin
                c_win = m_win; c_ctrl = m_ctrl; c_en = m_en; c_fs = m_fs;
            end
            chk($sformatf("r%0d_cfg_update", n), upd_cnt - u0, m_dirty ? 1 : 0);
            m_dirty = 0;
            chk($sformatf("r%0d_range_start", n), range_start, m_rs());
            chk($sformatf("r%0d_range_end", n), range_end, m_re());
            chk($sformatf("r%0d_enable", n), range_enable, c_en);
            chk($sformatf("r%0d_flash_sel", n), range_flash_select, c_fs);
            chk($sformatf("r%0d_control", n), control_reg, c_ctrl);
            chk($sformatf("r%0d_status", n), status_reg, {3'b000, m_bad, m_rej, 3'b000});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
